// File: rtl/rom_read_ctrl.sv
// Burst reader for a synchronous ROM: issues one word per ISSUE/HOLD pair and
// hands each word to a ready/valid consumer. Optional dout_par under DOUT_PARITY_EN.
module rom_read_ctrl #(
  parameter int ROM_DEPTH = 24,
  parameter int AW        = 5,
  parameter int DW        = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [AW-1:0] burst_len,
  input  logic          abort,
  output logic          cs,
  output logic          read_en,
  output logic [AW-1:0] addrb,
  input  logic [DW-1:0] datab,
  output logic [DW-1:0] dout,
  output logic          dout_valid,
  input  logic          dout_ready,
  output logic          busy,
  output logic          done,
`ifdef DOUT_PARITY_EN
  output logic          dout_par,
`endif
  output logic          err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    HOLD  = 2'd2,
    DONE  = 2'd3
  } state_e;

  // count is one bit wider so a full-depth burst fits even when ROM_DEPTH == 2**AW
  localparam logic [AW:0]   DEPTH_W   = (AW+1)'(ROM_DEPTH);
  localparam logic [AW-1:0] LAST_ADDR = AW'(ROM_DEPTH - 1);
  localparam logic [AW:0]   COUNT_ONE = (AW+1)'(1);

  function automatic logic even_parity(input logic [DW-1:0] data);
    return ^data;
  endfunction

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW:0]   count_q, count_d;
  logic          issue_q, issue_d;
  logic [DW-1:0] dout_q, dout_d;
  logic          dout_valid_q, dout_valid_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          par_q, par_d;

  logic          base_ok_s;
  logic [AW:0]   count_load_s;
  logic [AW-1:0] next_addr_s;

  assign base_ok_s    = ({1'b0, base_addr} < DEPTH_W);
  assign count_load_s = (burst_len == {AW{1'b0}}) ? DEPTH_W : {1'b0, burst_len};
  assign next_addr_s  = (addr_q == LAST_ADDR) ? {AW{1'b0}} : (addr_q + AW'(1'b1));

  // Next-state and next-output computation for the burst FSM.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    count_d      = count_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    err_d        = 1'b0;
    par_d        = par_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (base_ok_s) begin
            state_d = ISSUE;
            addr_d  = base_addr;
            count_d = count_load_s;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        state_d      = HOLD;
        dout_d       = datab;
        dout_valid_d = 1'b1;
        par_d        = even_parity(datab);
      end
      HOLD: begin
        if (dout_ready) begin
          dout_valid_d = 1'b0;
          if (count_q > COUNT_ONE) begin
            state_d = ISSUE;
            count_d = count_q - COUNT_ONE;
            addr_d  = next_addr_s;
          end else begin
            state_d = DONE;
          end
        end else begin
          state_d = HOLD;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d      = IDLE;
        dout_valid_d = 1'b0;
      end
    endcase

    // abort wins over a same-cycle handshake and suppresses the done pulse
    if (abort && (state_q != IDLE)) begin
      state_d      = IDLE;
      addr_d       = addr_q;
      count_d      = count_q;
      dout_valid_d = 1'b0;
    end else begin
      err_d = err_d;
    end

    issue_d = (state_d == ISSUE);
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == DONE);
  end

  // State and registered-output flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      addr_q       <= {AW{1'b0}};
      count_q      <= {(AW+1){1'b0}};
      issue_q      <= 1'b0;
      dout_q       <= {DW{1'b0}};
      dout_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      par_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      count_q      <= count_d;
      issue_q      <= issue_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
      par_q        <= par_d;
    end
  end

  assign cs         = issue_q;
  assign read_en    = issue_q;
  assign addrb      = addr_q;
  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
`ifdef DOUT_PARITY_EN
  assign dout_par   = par_q;
`else
  logic unused_par_s;
  assign unused_par_s = par_q;
`endif

endmodule

// File: tb/tb_rom_read_ctrl.sv
// Self-checking bench for rom_read_ctrl: a word-level reference model checked
// every cycle, plus directed bursts with hand-computed expectations.
module tb_rom_read_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [4:0] base_addr = 5'd0;
  logic [4:0] burst_len = 5'd0;
  logic       abort = 1'b0;
  logic       cs, read_en;
  logic [4:0] addrb;
  logic [7:0] datab;
  logic [7:0] dout;
  logic       dout_valid;
  logic       dout_ready = 1'b0;
  logic       busy, done, err;
`ifdef DOUT_PARITY_EN
  logic       dout_par;
`endif

  logic [7:0] rom [0:31];

  int n_checks = 0;
  int n_pass   = 0;
  int n_done   = 0;
  logic [7:0] obs_dout [$];
  int         obs_addr [$];
  logic       prev_dv = 1'b0;

  // reference model: word-level view of a burst
  bit         m_busy = 1'b0, m_issue = 1'b0, m_dv = 1'b0, m_doneph = 1'b0, m_err = 1'b0;
  int         m_addr = 0, m_left = 0;
  logic [7:0] m_dout = 8'h00;
  logic       m_par = 1'b0;

  rom_read_ctrl #(.ROM_DEPTH(24), .AW(5), .DW(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .burst_len(burst_len), .abort(abort), .cs(cs), .read_en(read_en),
    .addrb(addrb), .datab(datab), .dout(dout), .dout_valid(dout_valid),
    .dout_ready(dout_ready), .busy(busy), .done(done),
`ifdef DOUT_PARITY_EN
    .dout_par(dout_par),
`endif
    .err(err)
  );

  always #5 clk = ~clk;

  assign datab = (cs && read_en) ? rom[addrb] : 8'hEE;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 1'b0; m_issue = 1'b0; m_dv = 1'b0; m_doneph = 1'b0; m_err = 1'b0;
      m_addr = 0; m_left = 0; m_dout = 8'h00; m_par = 1'b0;
    end else begin
      m_err = 1'b0;
      if (!m_busy) begin
        if (start) begin
          if (int'(base_addr) < 24) begin
            m_busy = 1'b1; m_issue = 1'b1; m_addr = int'(base_addr);
            m_left = (burst_len == 5'd0) ? 24 : int'(burst_len);
          end else begin
            m_err = 1'b1;
          end
        end
      end else if (abort) begin
        m_busy = 1'b0; m_issue = 1'b0; m_dv = 1'b0; m_doneph = 1'b0;
      end else if (m_doneph) begin
        m_doneph = 1'b0; m_busy = 1'b0;
      end else if (m_issue) begin
        m_issue = 1'b0; m_dout = rom[m_addr]; m_par = ^rom[m_addr]; m_dv = 1'b1;
      end else if (dout_ready) begin
        m_dv = 1'b0;
        m_left = m_left - 1;
        if (m_left == 0) m_doneph = 1'b1;
        else begin
          m_addr = (m_addr + 1) % 24;
          m_issue = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("busy", 32'(busy), 32'(m_busy));
      chk("cs", 32'(cs), 32'(m_issue));
      chk("read_en", 32'(read_en), 32'(m_issue));
      chk("addrb", 32'(addrb), 32'(m_addr));
      chk("dout_valid", 32'(dout_valid), 32'(m_dv));
      chk("dout", 32'(dout), 32'(m_dout));
      chk("done", 32'(done), 32'(m_doneph));
      chk("err", 32'(err), 32'(m_err));
`ifdef DOUT_PARITY_EN
      chk("dout_par", 32'(dout_par), 32'(m_par));
`endif
      if (dout_valid && !prev_dv) obs_dout.push_back(dout);
      if (cs) obs_addr.push_back(int'(addrb));
      if (done) n_done++;
    end
    prev_dv = dout_valid;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic wait_done(input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick(1);
      if (done) seen = 1'b1;
    end
    chk("done_seen", 32'(seen), 32'd1);
    tick(1);
  endtask

  task automatic clear_obs();
    obs_dout.delete();
    obs_addr.delete();
    n_done = 0;
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_cs"}, 32'(cs), 32'd0);
    chk({tag, "_read_en"}, 32'(read_en), 32'd0);
    chk({tag, "_addrb"}, 32'(addrb), 32'd0);
    chk({tag, "_dout"}, 32'(dout), 32'd0);
    chk({tag, "_dout_valid"}, 32'(dout_valid), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rom[i] = (i < 24) ? 8'(8'h40 + i) : 8'h00;
    rom[0] = 8'h11; rom[1] = 8'h22; rom[2] = 8'h33;

    #1;
    check_zero_outputs("reset");
    tick(1);
    rst_n = 1'b1;
    tick(2);

    // three-word burst with consumer always ready
    clear_obs();
    dout_ready = 1'b1;
    start = 1'b1; base_addr = 5'd0; burst_len = 5'd3;
    tick(1);
    start = 1'b0;
    chk("lat_cs", 32'(cs), 32'd1);
    chk("lat_dv_early", 32'(dout_valid), 32'd0);
    tick(1);
    chk("lat_dv", 32'(dout_valid), 32'd1);
    chk("lat_dout", 32'(dout), 32'h11);
    wait_done(20);
    chk("b3_nwords", 32'(obs_dout.size()), 32'd3);
    if (obs_dout.size() == 3) begin
      chk("b3_w0", 32'(obs_dout[0]), 32'h11);
      chk("b3_w1", 32'(obs_dout[1]), 32'h22);
      chk("b3_w2", 32'(obs_dout[2]), 32'h33);
      chk("b3_a0", 32'(obs_addr[0]), 32'd0);
      chk("b3_a1", 32'(obs_addr[1]), 32'd1);
      chk("b3_a2", 32'(obs_addr[2]), 32'd2);
    end
    chk("b3_ndone", 32'(n_done), 32'd1);
    chk("b3_idle", 32'(busy), 32'd0);

    // address wrap at the top of the ROM
    clear_obs();
    start = 1'b1; base_addr = 5'd22; burst_len = 5'd4;
    tick(1);
    start = 1'b0;
    wait_done(20);
    chk("wrap_naddr", 32'(obs_addr.size()), 32'd4);
    if (obs_addr.size() == 4) begin
      chk("wrap_a0", 32'(obs_addr[0]), 32'd22);
      chk("wrap_a1", 32'(obs_addr[1]), 32'd23);
      chk("wrap_a2", 32'(obs_addr[2]), 32'd0);
      chk("wrap_a3", 32'(obs_addr[3]), 32'd1);
      chk("wrap_w2", 32'(obs_dout[2]), 32'h11);
    end

    // backpressure holds the word and blocks the next read
    clear_obs();
    dout_ready = 1'b0;
    start = 1'b1; base_addr = 5'd5; burst_len = 5'd2;
    tick(1);
    start = 1'b0;
    tick(1);
    for (int i = 0; i < 5; i++) begin
      chk("bp_dv", 32'(dout_valid), 32'd1);
      chk("bp_dout", 32'(dout), 32'h45);
      chk("bp_cs", 32'(cs), 32'd0);
      tick(1);
    end
    dout_ready = 1'b1;
    tick(1);
    chk("bp_reissue_cs", 32'(cs), 32'd1);
    chk("bp_reissue_addr", 32'(addrb), 32'd6);
    wait_done(20);

    // out-of-range start is rejected
    clear_obs();
    start = 1'b1; base_addr = 5'd26; burst_len = 5'd2;
    tick(1);
    start = 1'b0;
    chk("err_pulse", 32'(err), 32'd1);
    chk("err_busy", 32'(busy), 32'd0);
    chk("err_cs", 32'(cs), 32'd0);
    tick(1);
    chk("err_drop", 32'(err), 32'd0);
    tick(2);
    chk("err_no_issue", 32'(obs_addr.size()), 32'd0);

    // abort with a same-cycle handshake on the second word
    clear_obs();
    dout_ready = 1'b0;
    start = 1'b1; base_addr = 5'd3; burst_len = 5'd5;
    tick(1);
    start = 1'b0;
    tick(1);
    dout_ready = 1'b1;
    tick(1);
    dout_ready = 1'b0;
    tick(1);
    chk("ab_hold2", 32'(dout), 32'h44);
    dout_ready = 1'b1; abort = 1'b1;
    tick(1);
    abort = 1'b0;
    chk("ab_busy", 32'(busy), 32'd0);
    chk("ab_dv", 32'(dout_valid), 32'd0);
    chk("ab_done", 32'(done), 32'd0);
    start = 1'b1; base_addr = 5'd0; burst_len = 5'd1;
    tick(1);
    start = 1'b0;
    chk("ab_restart_cs", 32'(cs), 32'd1);
    chk("ab_restart_addr", 32'(addrb), 32'd0);
    wait_done(20);
    chk("ab_ndone", 32'(n_done), 32'd1);

    // asynchronous reset in HOLD discards the burst
    clear_obs();
    dout_ready = 1'b0;
    start = 1'b1; base_addr = 5'd2; burst_len = 5'd3;
    tick(1);
    start = 1'b0;
    tick(1);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero_outputs("arst");
    tick(1);
    rst_n = 1'b1;
    dout_ready = 1'b1;
    tick(6);
    chk("arst_no_done", 32'(n_done), 32'd0);
    chk("arst_idle", 32'(busy), 32'd0);

    // burst_len of zero reads the whole ROM
    clear_obs();
    start = 1'b1; base_addr = 5'd7; burst_len = 5'd0;
    tick(1);
    start = 1'b0;
    wait_done(80);
    chk("full_naddr", 32'(obs_addr.size()), 32'd24);
    if (obs_addr.size() == 24) begin
      for (int i = 0; i < 24; i++) chk("full_addr", 32'(obs_addr[i]), 32'((7 + i) % 24));
    end
    chk("full_ndone", 32'(n_done), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
